instr_fetch_unit: RTL and testbench

Fetch stage upstream of the single-cycle RISC-V core. Issues sequential fetch requests to a synchronous, fixed-latency instruction memory and buffers returned words in a small FIFO. Presents instructions with their PC over a valid/ready handshake to the decode/execute stage. Accepts branch/jump redirects from the core, which flush all buffered and in-flight fetches.

---
 rtl/instr_fetch_unit_pkg.sv | 12 +
 rtl/instr_fetch_unit_fifo.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 83 ++++++++
 tb/tb_instr_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared widths, reset PC and the buffered fetch entry type
package instr_fetch_unit_pkg;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int INSTRUCTION_MEMORY_ADDRESS_WIDTH = 10;
    localparam int FETCH_FIFO_DEPTH = 4;
    localparam logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0]                data;
        logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush, occupancy count and empty flag
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = FETCH_FIFO_DEPTH,
    parameter type entry_t = fetch_entry_t,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        din,
    output entry_t        dout,
    output logic [CW-1:0] count,
    output logic          empty
);
    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full;

    assign dout  = mem[rd_ptr];
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);

    // pointers and occupancy; flush discards everything buffered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // storage needs no reset: only entries below count are ever read as valid
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    // the issue credit makes a push into a full buffer impossible
    assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop && !flush))
        else $error("fetch_fifo overflow");
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited sequential fetch, instruction buffer and redirect flush
// Optional FETCH_BYPASS_EN: a response reaching an empty buffer goes straight to the consumer
module instr_fetch_unit #(
    parameter int INSTRUCTION_WIDTH = instr_fetch_unit_pkg::INSTRUCTION_WIDTH,
    parameter int ADDR_WIDTH = instr_fetch_unit_pkg::INSTRUCTION_MEMORY_ADDRESS_WIDTH,
    parameter int FIFO_DEPTH = instr_fetch_unit_pkg::FETCH_FIFO_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = instr_fetch_unit_pkg::RESET_PC
)(
    input  logic                         clk,
    input  logic                         rst,
    output logic                         mem_req,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic                         mem_rvalid,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]        instr_pc,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc
);
    import instr_fetch_unit_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0]        pc;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc, pend_pc;
    logic                  pending, accept, bypass, push, pop, empty;
    logic [CW-1:0]         count;
    entry_t                head, resp, out;

    assign resp = '{data: mem_rdata, pc: pend_pc};

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (resp),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    // request only while buffered plus in-flight words leave room; redirect blocks issue and output
    always_comb begin
        mem_req  = rst & ~redirect_valid & (count + CW'(pending) < CW'(FIFO_DEPTH));
        mem_addr = fetch_pc;
        accept   = mem_rvalid & pending & ~redirect_valid;
`ifdef FETCH_BYPASS_EN
        bypass      = accept & empty & instr_ready;
        instr_valid = ~redirect_valid & (~empty | accept);
        out         = empty ? resp : head;
`else
        bypass      = 1'b0;
        instr_valid = ~redirect_valid & ~empty;
        out         = head;
`endif
        push       = accept & ~bypass;
        pop        = instr_valid & instr_ready & ~empty;
        instr_data = instr_valid ? out.data : '0;
        instr_pc   = instr_valid ? out.pc : '0;
    end

    // fetch PC advances on issue, jumps on redirect; each request's PC rides alongside it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            pend_pc  <= RESET_PC;
            pending  <= 1'b0;
        end else begin
            fetch_pc <= redirect_valid ? {redirect_pc[ADDR_WIDTH-1:2], 2'b00}
                      : mem_req ? fetch_pc + ADDR_WIDTH'(4) : fetch_pc;
            pend_pc  <= fetch_pc;
            pending  <= mem_req;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 0, rst = 0;
    logic        mem_req, mem_rvalid;
    logic [9:0]  mem_addr, instr_pc, redirect_pc;
    logic [31:0] mem_rdata, instr_data;
    logic        instr_valid, instr_ready, redirect_valid;

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0, req_cnt = 0;
    logic        prev_stall = 0;
    logic [9:0]  prev_pc;
    logic [31:0] prev_data;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [9:0] a);
        return {a ^ 10'h2A5, 12'hABC, a};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // expected delivery order: sequential word addresses from the aligned start, wrapping at 1 KiB
    task automatic load_stream(input logic [9:0] start);
        logic [9:0] p;
        p = {start[9:2], 2'b00};
        sb.delete();
        for (int i = 0; i < 512; i++) begin
            sb.push_back('{pc: p, data: memfn(p)});
            p = p + 10'd4;
        end
    endtask

    task automatic redirect(input logic [9:0] pc);
        redirect_valid = 1;
        redirect_pc    = pc;
        load_stream(pc);
    endtask

    // fixed-latency memory
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rvalid <= 0;
            mem_rdata  <= '0;
            req_cnt    <= 0;
        end else begin
            mem_rvalid <= mem_req;
            mem_rdata  <= memfn(mem_addr);
            req_cnt    <= req_cnt + (mem_req ? 1 : 0);
        end
    end

    // monitor: pops the scoreboard on every handshake
    always @(negedge clk) begin
        if (rst) begin
            if (mem_req) check("addr_align", 64'(mem_addr[1:0]), 0);
            if (redirect_valid) begin
                check("redir_no_req", 64'(mem_req), 0);
                check("redir_no_valid", 64'(instr_valid), 0);
            end
            if (prev_stall && instr_valid) begin
                check("hold_pc", 64'(instr_pc), 64'(prev_pc));
                check("hold_data", 64'(instr_data), 64'(prev_data));
            end
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) check("sb_empty", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("instr_pc", 64'(instr_pc), 64'(e.pc));
                    check("instr_data", 64'(instr_data), 64'(e.data));
                end
            end
        end
        prev_stall = rst && instr_valid && !instr_ready;
        prev_pc    = instr_pc;
        prev_data  = instr_data;
    end

    // cycle 0 is the cycle whose inputs were just applied; clears a one-cycle redirect
    task automatic first_valid(input int exp_k, input int addr_k, input logic [9:0] exp_addr, input string nm);
        int k = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == addr_k) begin
                check({nm, "_req"}, 64'(mem_req), 1);
                check({nm, "_addr"}, 64'(mem_addr), 64'(exp_addr));
            end
            if (k < 0 && instr_valid) k = i;
            @(posedge clk); #1;
            redirect_valid = 0;
        end
        check({nm, "_latency"}, 64'(k), 64'(exp_k));
    endtask

    initial begin
        int gaps;
        instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 64'(mem_req), 0);
        check("rst_addr", 64'(mem_addr), 0);
        check("rst_valid", 64'(instr_valid), 0);
        check("rst_data", 64'(instr_data), 0);
        check("rst_pc", 64'(instr_pc), 0);

        // release with consumer stalled: buffer fills to exactly its depth
        @(posedge clk); #1;
        rst = 1;
        load_stream(10'h000);
        first_valid(LAT, 0, 10'h000, "reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("fill_reqs", 64'(req_cnt), 4);
        check("fill_stop", 64'(mem_req), 0);

        // release: sustained one instruction per cycle
        @(posedge clk); #1;
        instr_ready = 1;
        gaps = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            gaps += instr_valid ? 0 : 1;
        end
        check("throughput_gaps", 64'(gaps), 0);

        // three buffered plus one in flight, all dropped by a redirect
        @(posedge clk); #1;
        instr_ready = 0;
        redirect(10'h100);
        @(posedge clk); #1;
        redirect_valid = 0;
        repeat (4) begin @(posedge clk); #1; end
        check("credit_full", 64'(mem_req), 0);
        check("stalled_valid", 64'(instr_valid), 1);
        redirect(10'h040);
        instr_ready = 1;
        first_valid(LAT + 1, 1, 10'h040, "redir40");

        redirect(10'h3FC);
        first_valid(LAT + 1, 1, 10'h3FC, "wrap");

        redirect(10'h043);
        first_valid(LAT + 1, 1, 10'h040, "unaligned");

        redirect(10'h080);
        @(posedge clk); #1;
        redirect(10'h0C0);
        first_valid(LAT + 1, 1, 10'h0C0, "b2b");

        // async reset while an instruction is presented
        instr_ready = 0;
        @(negedge clk);
        check("pre_rst_valid", 64'(instr_valid), 1);
        #2 rst = 0;
        #1;
        check("async_valid", 64'(instr_valid), 0);
        check("async_data", 64'(instr_data), 0);
        check("async_pc", 64'(instr_pc), 0);
        check("async_req", 64'(mem_req), 0);
        load_stream(10'h000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        instr_ready = 1;
        first_valid(LAT, 0, 10'h000, "refetch");

        // random backpressure and redirects
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            instr_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 15) == 0) redirect(10'($urandom_range(0, 1023)));
            else redirect_valid = 0;
        end
        @(posedge clk); #1;
        redirect_valid = 0;
        instr_ready = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
